transaction_control: RTL and testbench
======================================

# transaction_control

Sequencing controller for the transaction datapath. On a `go` request it loads the entered amount and key into the datapath, then walks memory through three checks in order: sender balance (amount check), sender public key (key check), and both player balances (transfer). It waits for `done_step` after each check, writes the two updated balances back, and reports `success` or `fail`. It sits between the top-level UI/FSM glue and the datapath/memory pair, and is the only writer of player memory.

## Interface
Parameters:
- TIMEOUT, 15: maximum cycles spent in any wait state without `done_step` before aborting (1..15).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- go  in  1  start request; sampled only in IDLE.
- sender  in  1  0 = player 1 pays player 2; 1 = player 2 pays player 1.
- done_step  in  1  step-complete flag from datapath.
- p1_amount_out  in  11  updated player-1 word from datapath.
- p2_amount_out  in  11  updated player-2 word from datapath.
- process  out  3  step code to datapath: 000 idle, 001 amount, 010 key, 100 transfer.
- load_amount  out  1  one-cycle load strobe for datapath amount register.
- load_key  out  1  one-cycle load strobe for datapath key register.
- mem_address  out  2  memory word select: 0 = P1 balance, 1 = P2 balance, 2 = P1 key, 3 = P2 key.
- mem_write  out  1  memory write enable.
- mem_data  out  11  memory write data.
- busy  out  1  high in every state except IDLE.
- success  out  1  one-cycle pulse when a transaction commits.
- fail  out  1  one-cycle pulse when a transaction aborts.

## Operation
- States: IDLE, LOAD, RD_BAL, VER_AMT, RD_KEY, VER_KEY, RD_P1, RD_P2, XFER, WB1, WB2, DONE, FAIL.
- IDLE: if `go` is high, go to LOAD. `sender` is latched into an internal register on the same edge and held for the whole transaction.
- LOAD: `load_amount` = `load_key` = 1. Go to RD_BAL.
- RD_BAL: `mem_address` = sender balance (0 or 1). `process` = 001. Go to VER_AMT.
- VER_AMT: address and `process` held. If `done_step` = 1, go to RD_KEY. If the timeout expires, go to FAIL.
- RD_KEY: `mem_address` = sender key (2 or 3). `process` = 010. Go to VER_KEY.
- VER_KEY: address and `process` held. If `done_step` = 1, go to RD_P1. If the timeout expires, go to FAIL.
- RD_P1: `mem_address` = 0, `process` = 100. Go to RD_P2.
- RD_P2: `mem_address` = 1, `process` = 100. Go to XFER.
- XFER: `process` = 100, address held at 1. If `done_step` = 1, go to WB1. If the timeout expires, go to FAIL.
- WB1: `mem_address` = 0, `mem_write` = 1, `mem_data` = `p1_amount_out`. Go to WB2.
- WB2: `mem_address` = 1, `mem_write` = 1, `mem_data` = `p2_amount_out`. Go to DONE.
- DONE: `success` = 1. Go to IDLE.
- FAIL: `fail` = 1. Go to IDLE. No memory write ever occurs on any path that reaches FAIL.
- Timeout counter:
  - 4 bits, cleared on entry to each wait state (VER_AMT, VER_KEY, XFER).
  - Increments each cycle in the wait state while `done_step` = 0.
  - Expires when the count reaches TIMEOUT-1 with `done_step` still 0, i.e. after TIMEOUT cycles in the state.
  - `done_step` = 1 on the expiry cycle takes priority: the step passes.
- `process` is 100 through WB1 and WB2, so the datapath keeps its transfer inputs stable. It is 000 in IDLE, LOAD, DONE and FAIL.
- `done_step` is ignored outside the wait states.
- All outputs are registered (Moore, decoded from the state register).

## Timing
- Reset (async, any state): state goes to IDLE immediately, without waiting for a clock edge. All outputs go to 0, the counter clears, and the latched sender clears. A write in progress is abandoned; `mem_write` drops as soon as `resetn` falls.
- Memory read latency is 1 cycle: an address driven in cycle N gives valid `memory_out` to the datapath in N+1. Each RD_* state provides that cycle.
- Best case, with `done_step` high in the first cycle of each wait state, counting the edge that samples `go` as edge 0:
  - LOAD in cycle 1, DONE (`success`) in cycle 11, `busy` high for cycles 1-11, IDLE in cycle 12.
- Each extra wait cycle adds 1 cycle of latency.
- Worst-case abort: FAIL is reached in cycle 3 + TIMEOUT (amount step never completes).
- `go` held high continuously starts the next transaction in the first IDLE cycle after DONE or FAIL. There is no back-to-back within the same cycle.
- `go` while `busy` is ignored and not queued.
- `success` and `fail` are never high together, and each is exactly 1 cycle wide.

## Test plan
- Reset, then `go` with `sender`=0 and `done_step` tied high: LOAD strobes in cycle 1; writes to address 0 then 1 in cycles 9 and 10 with data equal to `p1_amount_out`/`p2_amount_out` (e.g. 11'h50A, 11'h614); `success` in cycle 11.
- `sender`=1: RD_BAL drives address 1 and RD_KEY drives address 3; otherwise identical, and `success` in cycle 11.
- `done_step` never asserted in VER_AMT, TIMEOUT=15: `fail` in cycle 18; `mem_write` never 1; `busy` low in cycle 19.
- `done_step` high in VER_AMT but low in VER_KEY for 15 cycles: `fail` pulse, no write; then `go` again with `done_step` high gives `success`.
- `resetn` pulsed low during WB1: `mem_write` and `busy` drop asynchronously; after release the block is in IDLE with all outputs 0 and WB2 never happens.
- `go` pulsed in cycle 4 of a running transaction: ignored; exactly one `success` is produced.

Source files
------------

// File: rtl/transaction_control.sv
// transaction_control: sequences a transfer through amount check, key check, transfer and balance write-back
module transaction_control #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        go,
  input  logic        sender,
  input  logic        done_step,
  input  logic [10:0] p1_amount_out,
  input  logic [10:0] p2_amount_out,
  output logic [2:0]  process,
  output logic        load_amount,
  output logic        load_key,
  output logic [1:0]  mem_address,
  output logic        mem_write,
  output logic [10:0] mem_data,
  output logic        busy,
  output logic        success,
  output logic        fail
);
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_RD_BAL, S_VER_AMT, S_RD_KEY, S_VER_KEY,
    S_RD_P1, S_RD_P2, S_XFER, S_WB1, S_WB2, S_DONE, S_FAIL
  } state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sender_q, sender_d;
  logic        wait_st, expired;
  logic [2:0]  process_d;
  logic [1:0]  addr_d;
  logic [10:0] data_d;
  // next state, wait counter and latched sender; outputs are decoded from the next state so they register in step with it
  always_comb begin
    wait_st  = state_q inside {S_VER_AMT, S_VER_KEY, S_XFER};
    expired  = wait_st && !done_step && cnt_q == 4'(TIMEOUT - 1);
    cnt_d    = (wait_st && !done_step) ? cnt_q + 4'd1 : '0;
    sender_d = (state_q == S_IDLE && go) ? sender : sender_q;
    state_d  = state_q;
    case (state_q)
      S_IDLE:    state_d = go ? S_LOAD : S_IDLE;
      S_LOAD:    state_d = S_RD_BAL;
      S_RD_BAL:  state_d = S_VER_AMT;
      S_VER_AMT: state_d = done_step ? S_RD_KEY : expired ? S_FAIL : S_VER_AMT;
      S_RD_KEY:  state_d = S_VER_KEY;
      S_VER_KEY: state_d = done_step ? S_RD_P1 : expired ? S_FAIL : S_VER_KEY;
      S_RD_P1:   state_d = S_RD_P2;
      S_RD_P2:   state_d = S_XFER;
      S_XFER:    state_d = done_step ? S_WB1 : expired ? S_FAIL : S_XFER;
      S_WB1:     state_d = S_WB2;
      S_WB2:     state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
    process_d = state_d inside {S_RD_BAL, S_VER_AMT} ? 3'b001 :
                state_d inside {S_RD_KEY, S_VER_KEY} ? 3'b010 :
                state_d inside {S_RD_P1, S_RD_P2, S_XFER, S_WB1, S_WB2} ? 3'b100 : 3'b000;
    addr_d    = state_d inside {S_RD_BAL, S_VER_AMT} ? {1'b0, sender_d} :
                state_d inside {S_RD_KEY, S_VER_KEY} ? {1'b1, sender_d} :
                state_d inside {S_RD_P2, S_XFER, S_WB2} ? 2'd1 : 2'd0;
    data_d    = state_d == S_WB1 ? p1_amount_out : state_d == S_WB2 ? p2_amount_out : '0;
  end
  // state, counter, sender latch and all registered outputs; reset abandons any write immediately
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sender_q    <= 1'b0;
      process     <= '0;
      load_amount <= 1'b0;
      load_key    <= 1'b0;
      mem_address <= '0;
      mem_write   <= 1'b0;
      mem_data    <= '0;
      busy        <= 1'b0;
      success     <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sender_q    <= sender_d;
      process     <= process_d;
      load_amount <= state_d == S_LOAD;
      load_key    <= state_d == S_LOAD;
      mem_address <= addr_d;
      mem_write   <= state_d inside {S_WB1, S_WB2};
      mem_data    <= data_d;
      busy        <= state_d != S_IDLE;
      success     <= state_d == S_DONE;
      fail        <= state_d == S_FAIL;
    end
endmodule

// File: tb/tb_transaction_control.sv
// tb_transaction_control: timeline model of each transaction checked against the DUT every cycle
module tb_transaction_control;
  localparam int TO = 15;
  logic        clock = 0, resetn = 0, go = 0, sender = 0, done_step = 0;
  logic [10:0] p1_amount_out = '0, p2_amount_out = '0;
  logic [2:0]  process;
  logic        load_amount, load_key, mem_write, busy, success, fail;
  logic [1:0]  mem_address;
  logic [10:0] mem_data;
  typedef struct packed {
    logic [2:0] proc; logic la; logic lk; logic [1:0] addr; logic wr;
    logic [10:0] data; logic busy; logic succ; logic fl;
  } out_t;
  out_t exp_cur = '0, act;
  out_t exp_q[$];
  bit   done_q[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, succ_cyc = -1, fail_cyc = -1, n_wr = 0, n_succ = 0;
  bit   chk_en = 0;
  transaction_control #(.TIMEOUT(TO)) dut (
    .clock(clock), .resetn(resetn), .go(go), .sender(sender), .done_step(done_step),
    .p1_amount_out(p1_amount_out), .p2_amount_out(p2_amount_out),
    .process(process), .load_amount(load_amount), .load_key(load_key),
    .mem_address(mem_address), .mem_write(mem_write), .mem_data(mem_data),
    .busy(busy), .success(success), .fail(fail)
  );
  always #5 clock = ~clock;
  assign act = {process, load_amount, load_key, mem_address, mem_write, mem_data, busy, success, fail};
  always @(negedge clock) if (chk_en) begin
    n_chk++;
    if (act !== exp_cur) begin
      n_fail++;
      $display("FAIL outputs cycle %0d: got proc=%b ld=%b%b addr=%0d wr=%b data=%h busy=%b succ=%b fl=%b, expected proc=%b ld=%b%b addr=%0d wr=%b data=%h busy=%b succ=%b fl=%b",
        cyc, act.proc, act.la, act.lk, act.addr, act.wr, act.data, act.busy, act.succ, act.fl,
        exp_cur.proc, exp_cur.la, exp_cur.lk, exp_cur.addr, exp_cur.wr, exp_cur.data, exp_cur.busy, exp_cur.succ, exp_cur.fl);
    end
    if (success) begin succ_cyc = cyc; n_succ++; end
    if (fail) fail_cyc = cyc;
    if (mem_write) n_wr++;
  end
  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask
  function automatic out_t mk(logic [2:0] p, logic la, logic [1:0] a, logic wr, logic [10:0] d, logic b, logic s, logic f);
    return out_t'({p, la, la, a, wr, d, b, s, f});
  endfunction
  function automatic void push(out_t e, bit d);
    exp_q.push_back(e);
    done_q.push_back(d);
  endfunction
  // one check step: done arrives in wait cycle w, or never within TO cycles which aborts
  function automatic bit wait_step(logic [2:0] p, logic [1:0] a, int w);
    for (int i = 0; i < TO; i++) begin
      push(mk(p, 0, a, 0, 0, 1, 0, 0), i == w);
      if (i == w) return 1;
    end
    push(mk(0, 0, 0, 0, 0, 1, 0, 1), 1);
    push(mk(0, 0, 0, 0, 0, 0, 0, 0), 1);
    return 0;
  endfunction
  // expected outputs and done_step to drive for cycles 1..N after the go edge
  function automatic void plan(bit snd, int wa, int wk, int wx, logic [10:0] v1, logic [10:0] v2);
    exp_q.delete();
    done_q.delete();
    push(mk(0, 1, 0, 0, 0, 1, 0, 0), 1);
    push(mk(3'b001, 0, {1'b0, snd}, 0, 0, 1, 0, 0), 1);
    if (!wait_step(3'b001, {1'b0, snd}, wa)) return;
    push(mk(3'b010, 0, {1'b1, snd}, 0, 0, 1, 0, 0), 1);
    if (!wait_step(3'b010, {1'b1, snd}, wk)) return;
    push(mk(3'b100, 0, 0, 0, 0, 1, 0, 0), 1);
    push(mk(3'b100, 0, 1, 0, 0, 1, 0, 0), 1);
    if (!wait_step(3'b100, 1, wx)) return;
    push(mk(3'b100, 0, 0, 1, v1, 1, 0, 0), 1);
    push(mk(3'b100, 0, 1, 1, v2, 1, 0, 0), 1);
    push(mk(0, 0, 0, 0, 0, 1, 1, 0), 1);
    push(mk(0, 0, 0, 0, 0, 0, 0, 0), 1);
  endfunction
  task automatic run(bit snd, int wa, int wk, int wx, logic [10:0] v1, logic [10:0] v2, int go_at, int stop_at);
    plan(snd, wa, wk, wx, v1, v2);
    p1_amount_out = v1;
    p2_amount_out = v2;
    @(negedge clock);
    go = 1; sender = snd; done_step = 0;
    @(posedge clock); #1;
    go = 0; sender = ~snd;
    succ_cyc = -1; fail_cyc = -1; n_wr = 0; n_succ = 0;
    for (int c = 1; c <= exp_q.size(); c++) begin
      cyc = c;
      exp_cur = exp_q[c-1];
      done_step = done_q[c-1];
      go = (c == go_at);
      if (c == stop_at) begin
        @(negedge clock); #1;
        return;
      end
      @(posedge clock); #1;
    end
  endtask
  initial begin
    #12;
    check("reset_outputs", act, 0);
    resetn = 1;
    chk_en = 1;
    run(0, 0, 0, 0, 11'h50A, 11'h614, 0, 0);
    check("s0_success_cycle", succ_cyc, 11);
    check("s0_writes", n_wr, 2);
    run(1, 0, 0, 0, 11'h123, 11'h7FF, 0, 0);
    check("s1_success_cycle", succ_cyc, 11);
    run(0, 99, 0, 0, 11'h111, 11'h222, 0, 0);
    check("amt_timeout_fail_cycle", fail_cyc, 18);
    check("amt_timeout_writes", n_wr, 0);
    run(1, 0, 99, 0, 11'h333, 11'h444, 0, 0);
    check("key_timeout_writes", n_wr, 0);
    check("key_timeout_success", n_succ, 0);
    run(1, 0, 0, 0, 11'h0AB, 11'h0CD, 0, 0);
    check("retry_success_cycle", succ_cyc, 11);
    run(0, 2, 3, 14, 11'h2C5, 11'h13A, 0, 0);
    check("slow_success_cycle", succ_cyc, 30);
    run(0, 0, 0, 0, 11'h055, 11'h0AA, 4, 0);
    check("go_busy_success_count", n_succ, 1);
    run(0, 0, 0, 0, 11'h3F0, 11'h00F, 0, 9);
    chk_en = 0;
    resetn = 0;
    #1;
    check("async_reset_write", mem_write, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_outputs", act, 0);
    @(posedge clock); #3;
    resetn = 1;
    exp_cur = '0;
    n_wr = 0;
    chk_en = 1;
    repeat (4) @(negedge clock);
    #1;
    check("no_wb2_after_reset", n_wr, 0);
    run(1, 1, 1, 1, 11'h321, 11'h123, 0, 0);
    check("post_reset_success_cycle", succ_cyc, 14);
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
